if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Sequencer for the instruction-fetch stage: PC register, PC+4 adder, IMEM, PC-select mux and IF/ID register.
- Owns the IMEM write port while a program is loaded over a valid/ready stream, then releases the PC from address 0.
- In RUN it gates PC and IF/ID updates for stalls, and squashes wrong-path instructions on a taken branch/jump.
- Stops fetch on halt.
- Sits beside the fetch datapath; the hazard unit, EX stage and testbench loader drive it.

Parameters:
ADDR_W, 8, IMEM word-address width; depth = 2**ADDR_W words
CNT_W, 16, width of the saturating stall and flush performance counters

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-high reset
ld_valid  in  1  loader word valid
ld_ready  out  1  controller accepts loader word (1 only in LOAD)
ld_data  in  32  instruction word to write
ld_last  in  1  marks final word of the program
imem_we  out  1  IMEM write enable
imem_waddr  out  ADDR_W  IMEM word write address
imem_wdata  out  32  IMEM write data (= ld_data)
pcsel_in  in  1  branch/jump taken, from EX (1 = take ALU target)
stall_in  in  1  load-use stall request, from hazard unit
halt_in  in  1  ecall/ebreak decoded in ID
reload_in  in  1  request new program load (honoured in HALT only)
pc_clear  out  1  synchronous PC clear to 0
pc_en  out  1  PC register load enable
pc_sel  out  1  PC mux select to the fetch datapath
ifid_en  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID register clears to NOP (0x00000013)
idex_flush  out  1  ID/EX register clears to bubble
running  out  1  state == RUN
halted  out  1  state == HALT
stall_cnt  out  CNT_W  cycles stalled in RUN, saturating
flush_cnt  out  CNT_W  taken-branch flush events, saturating

Behaviour:
- States: LOAD, START, RUN, HALT. Reset (async) forces LOAD, clears wr_ptr, stall_cnt and flush_cnt.
- Outputs during and right after reset: ld_ready=1, all other control outputs 0, counters 0.
- All control outputs are combinational from state and inputs. State, wr_ptr and counters are registered.
- LOAD:
  - ld_ready=1. A handshake (ld_valid & ld_ready) gives imem_we=1, imem_waddr=wr_ptr, imem_wdata=ld_data, and wr_ptr increments at the edge.
  - Handshake with ld_last=1, or handshake with wr_ptr = 2**ADDR_W-1, moves to START (no wrap or overwrite).
  - pc_en=ifid_en=0.
  - ld_valid=0 simply waits; no timeout.
- START: exactly one cycle.
  - pc_clear=1, ifid_flush=1, idex_flush=1, ld_ready=0.
  - Moves to RUN. The first fetch is address 0 on the following cycle.
- RUN:
  - Default: pc_en=1, ifid_en=1, pc_sel=0.
  - stall_in=1 (no branch): pc_en=0, ifid_en=0, idex_flush=1; stall_cnt+1.
  - pcsel_in=1: pc_sel=1, pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt+1. This squashes the two wrong-path instructions in IF and ID.
  - Branch and stall in the same cycle: the branch wins (stall ignored, stall_cnt unchanged).
  - halt_in=1 with pcsel_in=0: go to HALT. This cycle pc_en=0, ifid_en=0.
  - halt_in=1 with pcsel_in=1: the branch wins and the halt is squashed as wrong-path; stay in RUN.
- HALT:
  - pc_en=ifid_en=0, pc_sel=0, halted=1. Counters hold.
  - reload_in=1 moves to LOAD and clears wr_ptr; counters are not cleared.
  - reload_in outside HALT is ignored.
- pc_sel is forced 0 in every state except RUN, so unknown or floating pcsel_in outside RUN has no effect.
- Counters saturate at 2**CNT_W-1.
- Reset mid-load or mid-run aborts immediately. IMEM contents are not touched by reset; wr_ptr restarts at 0.

Decomposition:
- Shared package holds:
  - the state encoding enum (LOAD=0, START=1, RUN=2, HALT=3)
  - the NOP constant 32'h00000013
  - default ADDR_W/CNT_W
- One natural sub-module: sat_counter (parameter W; inputs inc, clr; output count). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Reset then load 4 words (0x00500093, 0x00100113, 0x002081B3, 0x00000073; last on 4th) -> imem_we pulses at waddr 0..3; one START cycle with pc_clear=1; running=1 next cycle.
- Loader holds ld_valid=0 for 5 cycles mid-load -> no imem_we, wr_ptr frozen, still LOAD; resumes at the next address.
- Load 2**ADDR_W words with no ld_last -> after word 255 (ADDR_W=8) state goes to START; no write to address 0 again.
- RUN, stall_in=1 for 3 cycles -> pc_en=ifid_en=0 and idex_flush=1 each cycle, stall_cnt=3. Same cycle pcsel_in=1 and stall_in=1 -> pc_sel=1, pc_en=1, ifid_flush=idex_flush=1, flush_cnt+1, stall_cnt unchanged.
- RUN, halt_in=1 -> halted=1 next cycle, pc_en=0. reload_in=1 -> LOAD, ld_ready=1, new load writes from address 0.
- Assert reset during RUN for 1 cycle -> state LOAD immediately (async), counters 0, ld_ready=1, pc_en=0.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Encoding the fetch datapath loads into IF/ID when it is flushed (addi x0,x0,0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/if_fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise increment until all ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: program load into IMEM, PC release, stall/flush gating, halt.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic              pcsel_in,
  input  logic              stall_in,
  input  logic              halt_in,
  input  logic              reload_in,
  output logic              pc_clear,
  output logic              pc_en,
  output logic              pc_sel,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              stall_inc;
  logic              flush_inc;

  // State and load-pointer registers; reset aborts any load or run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Next state and all control outputs, decoded from state and inputs.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    ld_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_waddr = wr_ptr_q;
    imem_wdata = ld_data;
    pc_clear   = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          imem_we  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          // The top address ends the load so IMEM is never wrapped over.
          if (ld_last || (wr_ptr_q == '1)) begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        pc_clear   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (pcsel_in) begin
          // A taken branch overrides stall and halt: both belong to squashed wrong-path work.
          pc_sel     = 1'b1;
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_inc  = 1'b1;
        end else begin
          if (stall_in) begin
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end
          if (halt_in) begin
            state_d = ST_HALT;
          end
          if (!stall_in && !halt_in) begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (reload_in) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign running = (state_q == ST_RUN);
  assign halted  = (state_q == ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (stall_inc),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (flush_inc),
    .clr   (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl against a phase-level reference model.
module tb_if_fetch_ctrl;

  localparam int unsigned AW   = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;
  localparam int unsigned TOP  = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid, ld_ready, ld_last;
  logic [31:0]   ld_data, imem_wdata;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic          pcsel_in, stall_in, halt_in, reload_in;
  logic          pc_clear, pc_en, pc_sel, ifid_en, ifid_flush, idex_flush;
  logic          running, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  typedef enum {M_LOAD, M_START, M_RUN, M_HALT} mphase_e;
  mphase_e     m_phase;
  int unsigned m_wp;
  int unsigned m_sc;
  int unsigned m_fc;

  if_fetch_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .pcsel_in   (pcsel_in),
    .stall_in   (stall_in),
    .halt_in    (halt_in),
    .reload_in  (reload_in),
    .pc_clear   (pc_clear),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .ifid_en    (ifid_en),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .running    (running),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_LOAD;
    m_wp    = 0;
    m_sc    = 0;
    m_fc    = 0;
  endtask

  // Compare every output against what the phase rules demand for the current inputs.
  task automatic check_all();
    logic in_run, br, hold;
    in_run = (m_phase == M_RUN);
    br     = in_run && (pcsel_in === 1'b1);
    hold   = in_run && !br && ((stall_in === 1'b1) || (halt_in === 1'b1));
    chk("ld_ready",   {31'd0, ld_ready},   {31'd0, m_phase == M_LOAD});
    chk("imem_we",    {31'd0, imem_we},    {31'd0, (m_phase == M_LOAD) && (ld_valid === 1'b1)});
    if ((m_phase == M_LOAD) && (ld_valid === 1'b1)) begin
      chk("imem_waddr", {24'd0, imem_waddr}, m_wp);
      chk("imem_wdata", imem_wdata, ld_data);
    end
    chk("pc_clear",   {31'd0, pc_clear},   {31'd0, m_phase == M_START});
    chk("pc_en",      {31'd0, pc_en},      {31'd0, in_run && !hold});
    chk("ifid_en",    {31'd0, ifid_en},    {31'd0, in_run && !hold});
    chk("pc_sel",     {31'd0, pc_sel},     {31'd0, br});
    chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, (m_phase == M_START) || br});
    chk("idex_flush", {31'd0, idex_flush},
        {31'd0, (m_phase == M_START) || br || (in_run && (stall_in === 1'b1))});
    chk("running",    {31'd0, running},    {31'd0, in_run});
    chk("halted",     {31'd0, halted},     {31'd0, m_phase == M_HALT});
    chk("stall_cnt",  {28'd0, stall_cnt},  m_sc);
    chk("flush_cnt",  {28'd0, flush_cnt},  m_fc);
  endtask

  // Advance the model by one rising edge using the inputs presented this cycle.
  task automatic model_clock();
    case (m_phase)
      M_LOAD: if (ld_valid === 1'b1) begin
        if ((ld_last === 1'b1) || (m_wp == TOP)) m_phase = M_START;
        m_wp = (m_wp + 1) % (TOP + 1);
      end
      M_START: m_phase = M_RUN;
      M_RUN: begin
        if (pcsel_in === 1'b1) begin
          if (m_fc < CMAX) m_fc++;
        end else begin
          if ((stall_in === 1'b1) && (m_sc < CMAX)) m_sc++;
          if (halt_in === 1'b1) m_phase = M_HALT;
        end
      end
      M_HALT: if (reload_in === 1'b1) begin
        m_phase = M_LOAD;
        m_wp    = 0;
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic last,
                      input logic ps, input logic st, input logic hl, input logic rl);
    ld_valid  = v;
    ld_data   = d;
    ld_last   = last;
    pcsel_in  = ps;
    stall_in  = st;
    halt_in   = hl;
    reload_in = rl;
    #1;
    check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run(input logic ps, input logic st, input logic hl);
    step(1'b0, 32'd0, 1'b0, ps, st, hl, 1'b0);
  endtask

  logic [31:0] prog [4];
  int unsigned n;

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0073;
    reset = 1'b1;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    pcsel_in = 1'b0; stall_in = 1'b0; halt_in = 1'b0; reload_in = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Four-word program with a five-cycle loader gap after the second word.
    step(1'b1, prog[0], 1'b0, 1'bx, 1'b0, 1'b0, 1'b0);
    step(1'b1, prog[1], 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) idle();
    step(1'b1, prog[2], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, prog[3], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_clear", {31'd0, pc_clear}, 32'd1);
    idle();
    chk("run_after_start", {31'd0, running}, 32'd1);

    // Stalls, then branch-over-stall, then branch-over-halt, then halt.
    run(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run(1'b0, 1'b1, 1'b0);
    chk("stall_cnt_3", {28'd0, stall_cnt}, 32'd3);
    run(1'b1, 1'b1, 1'b0);
    chk("stall_kept", {28'd0, stall_cnt}, 32'd3);
    chk("flush_one", {28'd0, flush_cnt}, 32'd1);
    run(1'b1, 1'b0, 1'b1);
    chk("halt_squashed", {31'd0, running}, 32'd1);
    run(1'b0, 1'b0, 1'b1);
    chk("halted_now", {31'd0, halted}, 32'd1);
    run(1'b1, 1'b1, 1'b0);
    run(1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reload_ready", {31'd0, ld_ready}, 32'd1);

    // Full-depth load without ld_last: ends after the top address.
    for (int unsigned a = 0; a <= TOP; a++)
      step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_load_start", {31'd0, pc_clear}, 32'd1);
    chk("full_load_no_we", {31'd0, imem_we}, 32'd0);
    idle();

    // Drive the stall counter into saturation.
    for (int i = 0; i < 20; i++) run(1'b0, 1'b1, 1'b0);
    chk("stall_sat", {28'd0, stall_cnt}, CMAX);

    // Asynchronous reset in the middle of a RUN cycle.
    run(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_ready", {31'd0, ld_ready}, 32'd1);
    chk("arst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("arst_running", {31'd0, running}, 32'd0);
    chk("arst_stall", {28'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Randomised programs and run sequences, each ended by a halt and reload.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 12);
      for (int unsigned w = 0; w < n; w++) begin
        while ($urandom_range(0, 3) == 0) idle();
        step(1'b1, $urandom, (w == n - 1), $urandom_range(0, 1), 1'b0, 1'b0, 1'b0);
      end
      idle();
      for (int c = 0; c < 40; c++)
        run(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0) && (m_phase == M_RUN) && 1'b0 || ($urandom_range(0, 9) == 0) && 1'b0);
      run(1'b0, ($urandom_range(0, 1) == 1), 1'b1);
      idle();
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
